ks_pipe_subtractor: RTL and testbench
=====================================

Name: ks_pipe_subtractor

Overview:
- Pipelined W-bit parallel-prefix (Kogge-Stone) subtractor: D = A - B - Bin.
- Internally computes A + ~B + ~Bin with a log2(W)-level prefix carry network.
- Produces borrow-out and zero/signed-overflow flags.
- Inverse-operation companion to the team's Kogge-Stone adder; feeds the datapath ALU through a valid/ready stream interface with full backpressure.

Parameters:
- W, 4, operand/result width in bits (power of two, 2..32); prefix levels = log2(W).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept operand beat this cycle
- A  input  W  minuend, unsigned or two's complement
- B  input  W  subtrahend
- Bin  input  1  borrow-in
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result this cycle
- D  output  W  difference, modulo 2^W
- Bout  output  1  borrow-out (1 when A < B + Bin, unsigned)
- Z  output  1  D == 0
- V  output  1  signed overflow

Behaviour:
- Reset is synchronous: rst_n low at a clk edge clears all stage valid bits. out_valid=0, D=0, Bout=0, Z=0, V=0. Data registers are also zeroed.
- in_ready is 1 in the first cycle after reset.
- Global advance: adv = !out_valid || out_ready; in_ready = adv (combinational).
- Input beat is accepted on a clk edge with in_valid && in_ready.
- Stage 1 (PG) registers:
  - P = A ^ ~B, G = A & ~B, c0 = ~Bin.
  - The operand MSBs A[W-1] and B[W-1] are carried along for the V flag.
  - Valid bit v1 = in_valid when adv.
- Stage 2 (prefix):
  - log2(W) Kogge-Stone levels are combinational between stage 1 and stage 2.
  - Level k span 2^k: (G,P)[i] = (G[i] | P[i]&G[i-2^k], P[i]&P[i-2^k]) for i >= 2^k; otherwise pass through.
  - c0 is folded in as bit -1 generate.
  - Group carries C[i] (carry into bit i+1) are registered with P, v2 = v1.
- Stage 3 (output) registers:
  - D[i] = P[i] ^ C[i-1], with C[-1] = c0.
  - Bout = ~C[W-1].
  - Z = (D == 0).
  - V = (A[W-1] ^ B[W-1]) & (A[W-1] ^ D[W-1]).
  - out_valid = v2.
- Latency: exactly 3 cycles from acceptance to out_valid when out_ready is held 1. Throughput is 1 beat/cycle.
- Stall: when adv=0, all stage registers hold, including bubbles. Bubbles are not collapsed, so the capacity in flight is 3 beats.
- D, Bout, Z and V must stay stable while out_valid && !out_ready.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- When out_valid=0, the D/flag outputs are don't-care for checking but must be deterministic.
- Bin=1 with A=B gives D = all-ones and Bout=1.
- Reset mid-operation: all in-flight beats are discarded and no out_valid pulse follows. The first beat accepted after reset emerges 3 cycles later.
- Simultaneous out_ready=1 and in_valid=1 while full: one beat retires and one enters in the same cycle.

Test Plan:
- W=4, A=5, B=3, Bin=0, out_ready=1 -> 3 cycles later out_valid=1, D=2, Bout=0, Z=0, V=0.
- W=4, A=3, B=5, Bin=0 -> D=0xE, Bout=1, Z=0, V=0. Then A=4, B=3, Bin=1 -> D=0, Bout=0, Z=1, V=0.
- W=4, A=7, B=0xF, Bin=0 -> D=8, Bout=1, V=1. Then A=0, B=0, Bin=1 -> D=0xF, Bout=1, V=0.
- Backpressure: out_ready=0 while streaming beats (1,0),(2,0),(3,0),(4,0), all Bin=0.
  - Exactly 3 are accepted, then in_ready=0 and outputs hold D=1.
  - Raise out_ready -> D=1,2,3,4 in order on consecutive cycles, with no loss.
- Reset mid-flight: 2 beats accepted, then rst_n=0 for 1 cycle -> out_valid stays 0 until a new beat is accepted. That new beat emerges exactly 3 cycles later.
- Random: 10k beats at W=8 and W=16 with random in_valid/out_ready -> every D/Bout/Z/V matches a reference model (A-B-Bin), in order.

Source files
------------

// File: rtl/ks_pipe_subtractor_if.sv
// ---------------------------------------------------------------------------
// ks_pipe_subtractor_if
//   Operand/result stream bundle for ks_pipe_subtractor.
//
//   Handshake semantics (both directions): a beat moves on a rising clk edge
//   when its valid and ready are both 1 at that edge. A producer holds valid
//   and its payload stable until the beat moves. A producer never waits for
//   ready before raising valid. Ready may depend combinationally on the
//   consumer's state, but never on valid from the same side.
//
//   Signals
//     in_valid  : operand beat valid                  (master -> slave)
//     in_ready  : slave accepts an operand beat        (slave  -> master)
//     A, B, Bin : minuend, subtrahend, borrow-in       (master -> slave)
//     out_valid : result beat valid                    (slave  -> master)
//     out_ready : master accepts the result beat       (master -> slave)
//     D         : difference modulo 2^W                (slave  -> master)
//     Bout      : borrow-out, unsigned A < B + Bin     (slave  -> master)
//     Z         : D == 0                               (slave  -> master)
//     V         : signed overflow                      (slave  -> master)
// ---------------------------------------------------------------------------
interface ks_pipe_subtractor_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         Bout;
    logic         Z;
    logic         V;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, D, Bout, Z, V
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, D, Bout, Z, V
    );
endinterface

// File: rtl/ks_pipe_subtractor.sv
// ---------------------------------------------------------------------------
// ks_pipe_subtractor
//   Three-stage pipelined Kogge-Stone subtractor: D = A - B - Bin, computed as
//   A + ~B + ~Bin. Stage 1 registers bitwise propagate/generate, stage 2
//   registers the group carries produced by log2(W) prefix levels, stage 3
//   registers the difference and the Bout/Z/V flags.
//
//   Ports
//     clk   : rising-edge clock
//     rst_n : synchronous active-low reset, clears valid and data registers
//     bus   : slave side of ks_pipe_subtractor_if (operand in, result out)
//
//   Flow control: every stage advances together when the output register is
//   empty or being drained (adv). Bubbles are kept, so up to three beats are
//   in flight and in_ready equals adv.
// ---------------------------------------------------------------------------
module ks_pipe_subtractor #(
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ks_pipe_subtractor_if.slave  bus
);
    localparam int L = $clog2(W);

    logic adv;

    // Stage 1: propagate/generate of A + ~B, carry-in, operand sign bits
    logic         v1;
    logic [W-1:0] s1_p;
    logic [W-1:0] s1_g;
    logic         s1_c0;
    logic         s1_am;
    logic         s1_bm;

    // Stage 2: group carries, propagate kept for the final xor
    logic         v2;
    logic [W-1:0] s2_p;
    logic [W-1:0] s2_c;
    logic         s2_c0;
    logic         s2_am;
    logic         s2_bm;

    // Stage 3: result register driving the bus
    logic         v3;
    logic [W-1:0] d_q;
    logic         bout_q;
    logic         z_q;
    logic         ovf_q;

    // Prefix network, level 0 is the stage-1 output
    logic [L:0][W-1:0] gl;
    logic [L:0][W-1:0] pl;
    logic              unused_p;

    logic [W-1:0] d_next;
    logic         ovf_next;

    assign adv          = !v3 || bus.out_ready;
    assign bus.in_ready = adv;

    // The carry-in acts as a generate at bit -1; merging it into bit 0 up
    // front lets log2(W) levels reach every bit without an extra level.
    assign gl[0] = {s1_g[W-1:1], s1_g[0] | (s1_p[0] & s1_c0)};
    assign pl[0] = s1_p;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        for (genvar i = 0; i < W; i++) begin : g_bit
            if (i >= (1 << k)) begin : g_op
                assign gl[k+1][i] = gl[k][i] | (pl[k][i] & gl[k][i-(1<<k)]);
                assign pl[k+1][i] = pl[k][i] & pl[k][i-(1<<k)];
            end else begin : g_pass
                assign gl[k+1][i] = gl[k][i];
                assign pl[k+1][i] = pl[k][i];
            end
        end
    end

    // Group propagate of the last level is not needed for the carries.
    assign unused_p = ^pl[L];

    // s2_c[i] is the carry into bit i+1; the carry into bit 0 is c0.
    assign d_next   = s2_p ^ {s2_c[W-2:0], s2_c0};
    assign ovf_next = (s2_am ^ s2_bm) & (s2_am ^ d_next[W-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            s1_p   <= '0;
            s1_g   <= '0;
            s1_c0  <= 1'b0;
            s1_am  <= 1'b0;
            s1_bm  <= 1'b0;
            v2     <= 1'b0;
            s2_p   <= '0;
            s2_c   <= '0;
            s2_c0  <= 1'b0;
            s2_am  <= 1'b0;
            s2_bm  <= 1'b0;
            v3     <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
            z_q    <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            v1     <= bus.in_valid;
            s1_p   <= bus.A ^ ~bus.B;
            s1_g   <= bus.A & ~bus.B;
            s1_c0  <= ~bus.Bin;
            s1_am  <= bus.A[W-1];
            s1_bm  <= bus.B[W-1];

            v2     <= v1;
            s2_p   <= s1_p;
            s2_c   <= gl[L];
            s2_c0  <= s1_c0;
            s2_am  <= s1_am;
            s2_bm  <= s1_bm;

            v3     <= v2;
            d_q    <= d_next;
            bout_q <= ~s2_c[W-1];
            z_q    <= (d_next == '0);
            ovf_q  <= ovf_next;
        end
    end

    assign bus.out_valid = v3;
    assign bus.D         = d_q;
    assign bus.Bout      = bout_q;
    assign bus.Z         = z_q;
    assign bus.V         = ovf_q;
endmodule

// File: tb/tb_ks_pipe_subtractor.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_ks_pipe_subtractor
//   Three instances (W=4 directed, W=8 and W=16 random) sharing clk/rst_n.
//   Inputs change on the falling edge; outputs are read on the falling edge
//   after inputs settle, so every handshake seen there happens at the next
//   rising edge.
// ---------------------------------------------------------------------------
module tb_ks_pipe_subtractor;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ks_pipe_subtractor_if #(.W(4))  bus4 ();
    ks_pipe_subtractor_if #(.W(8))  bus8 ();
    ks_pipe_subtractor_if #(.W(16)) bus16 ();

    ks_pipe_subtractor #(.W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    ks_pipe_subtractor #(.W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    ks_pipe_subtractor #(.W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    // Reference: plain integer arithmetic, packed as {V, Z, Bout, D[31:0]}.
    function automatic logic [34:0] ref_model(input int w, input longint a,
                                              input longint b, input longint bin);
        longint half;
        longint mask;
        longint diff;
        longint d;
        longint sa;
        longint sb;
        longint sd;
        logic   ovf;
        logic   bo;
        logic   zf;
        logic [31:0] d32;
        half = longint'(1) << (w - 1);
        mask = (half << 1) - 1;
        diff = a - b - bin;
        d    = diff & mask;
        bo   = (diff < 0);
        zf   = (d == 0);
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        sd   = sa - sb - bin;
        ovf  = (sd < -half) || (sd >= half);
        d32  = d[31:0];
        return {ovf, zf, bo, d32};
    endfunction

    task automatic idle_all();
        bus4.in_valid  = 1'b0; bus4.A  = '0; bus4.B  = '0; bus4.Bin  = 1'b0; bus4.out_ready  = 1'b0;
        bus8.in_valid  = 1'b0; bus8.A  = '0; bus8.B  = '0; bus8.Bin  = 1'b0; bus8.out_ready  = 1'b0;
        bus16.in_valid = 1'b0; bus16.A = '0; bus16.B = '0; bus16.Bin = 1'b0; bus16.out_ready = 1'b0;
    endtask

    // Drives one beat into the empty W=4 pipe and reports how many rising
    // edges (acceptance edge included) it took to reach out_valid.
    task automatic run_beat4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                             output int lat, output logic [3:0] d,
                             output logic bo, output logic zf, output logic ovf);
        @(negedge clk);
        bus4.A = a; bus4.B = b; bus4.Bin = bin;
        bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        while (!bus4.out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        d = bus4.D; bo = bus4.Bout; zf = bus4.Z; ovf = bus4.V;
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus4.out_valid); end
        total++; if (bus4.D !== 4'h0) begin bad++; $display("FAIL reset_d got=%h want=0", bus4.D); end
        total++; if ({bus4.Bout, bus4.Z, bus4.V} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {bus4.Bout, bus4.Z, bus4.V}); end
        total++; if ({bus8.out_valid, bus16.out_valid} !== 2'b00) begin bad++; $display("FAIL reset_wide_valid got=%b want=00", {bus8.out_valid, bus16.out_valid}); end
        rst_n = 1'b1;
        #1;
        total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus4.in_ready); end
    endtask

    task automatic test_basic();
        logic [3:0] ta  [6] = '{4'h5, 4'h3, 4'h4, 4'h7, 4'h0, 4'h9};
        logic [3:0] tb  [6] = '{4'h3, 4'h5, 4'h3, 4'hF, 4'h0, 4'h9};
        logic       tc  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] td  [6] = '{4'h2, 4'hE, 4'h0, 4'h8, 4'hF, 4'hF};
        logic       tbo [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       tz  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       tv  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int         lat;
        logic [3:0] d;
        logic       bo;
        logic       zf;
        logic       ovf;
        for (int n = 0; n < 6; n++) begin
            run_beat4(ta[n], tb[n], tc[n], lat, d, bo, zf, ovf);
            total++; if (lat !== 3) begin bad++; $display("FAIL basic%0d_latency got=%0d want=3", n, lat); end
            total++; if (d !== td[n]) begin bad++; $display("FAIL basic%0d_d got=%h want=%h", n, d, td[n]); end
            total++; if (bo !== tbo[n]) begin bad++; $display("FAIL basic%0d_bout got=%b want=%b", n, bo, tbo[n]); end
            total++; if (zf !== tz[n]) begin bad++; $display("FAIL basic%0d_z got=%b want=%b", n, zf, tz[n]); end
            total++; if (ovf !== tv[n]) begin bad++; $display("FAIL basic%0d_v got=%b want=%b", n, ovf, tv[n]); end
        end
    endtask

    task automatic test_backpressure();
        int         acc = 0;
        int         got = 0;
        int         first_c = -1;
        int         last_c = -1;
        logic [3:0] seen [4];
        @(negedge clk);
        bus4.out_ready = 1'b0; bus4.B = 4'h0; bus4.Bin = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus4.in_valid = (acc < 4);
            bus4.A = 4'(acc + 1);
            #1;
            if (bus4.in_valid && bus4.in_ready) acc++;
            @(negedge clk);
        end
        #1;
        total++; if (acc !== 3) begin bad++; $display("FAIL bp_accepted got=%0d want=3", acc); end
        total++; if (bus4.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", bus4.in_ready); end
        total++; if (bus4.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid got=%b want=1", bus4.out_valid); end
        total++; if (bus4.D !== 4'h1) begin bad++; $display("FAIL bp_hold_d got=%h want=1", bus4.D); end
        bus4.out_ready = 1'b1;
        for (int c = 0; c < 12 && got < 4; c++) begin
            bus4.in_valid = (acc < 4);
            bus4.A = 4'(acc + 1);
            #1;
            if (c == 0) begin
                total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL bp_full_in_ready got=%b want=1", bus4.in_ready); end
            end
            if (bus4.out_valid) begin
                seen[got] = bus4.D;
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
            if (bus4.in_valid && bus4.in_ready) acc++;
            @(negedge clk);
        end
        bus4.in_valid = 1'b0;
        #1;
        total++; if (got !== 4) begin bad++; $display("FAIL bp_drain_count got=%0d want=4", got); end
        for (int i = 0; i < 4 && i < got; i++) begin
            total++; if (seen[i] !== 4'(i + 1)) begin bad++; $display("FAIL bp_order%0d got=%h want=%h", i, seen[i], 4'(i + 1)); end
        end
        total++; if (last_c - first_c !== 3) begin bad++; $display("FAIL bp_consecutive got_span=%0d want=3", last_c - first_c); end
        total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_extra got=%b want=0", bus4.out_valid); end
    endtask

    task automatic test_reset_midflight();
        int         pulses = 0;
        int         lat;
        logic [3:0] d;
        logic       bo;
        logic       zf;
        logic       ovf;
        @(negedge clk);
        bus4.out_ready = 1'b1; bus4.B = 4'h0; bus4.Bin = 1'b0;
        for (int c = 0; c < 2; c++) begin
            bus4.in_valid = 1'b1;
            bus4.A = 4'(c + 6);
            @(negedge clk);
        end
        bus4.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", bus4.out_valid); end
        total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%b want=1", bus4.in_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus4.out_valid) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL rst_mid_pulses got=%0d want=0", pulses); end
        run_beat4(4'hA, 4'h3, 1'b0, lat, d, bo, zf, ovf);
        total++; if (lat !== 3) begin bad++; $display("FAIL rst_mid_latency got=%0d want=3", lat); end
        total++; if ({ovf, zf, bo, d} !== {1'b1, 1'b0, 1'b0, 4'h7}) begin bad++; $display("FAIL rst_mid_result got=%b want=%b", {ovf, zf, bo, d}, {1'b1, 1'b0, 1'b0, 4'h7}); end
    endtask

    task automatic test_random();
        int          n_beats = 10000;
        logic [34:0] q8 [$];
        logic [34:0] q16 [$];
        logic [34:0] exp_v;
        logic [34:0] obs8;
        logic [34:0] obs16;
        logic [34:0] held8 = '0;
        logic [34:0] held16 = '0;
        logic        hold8 = 1'b0;
        logic        hold16 = 1'b0;
        int          sent8 = 0;
        int          sent16 = 0;
        int          rcv8 = 0;
        int          rcv16 = 0;
        int          cyc = 0;
        @(negedge clk);
        while ((rcv8 < n_beats || rcv16 < n_beats) && cyc < 80000) begin
            bus8.in_valid   = (sent8 < n_beats) && ($urandom_range(0, 3) != 0);
            bus8.A          = 8'($urandom);
            bus8.B          = 8'($urandom);
            bus8.Bin        = 1'($urandom_range(0, 1));
            bus8.out_ready  = ($urandom_range(0, 3) != 0);
            bus16.in_valid  = (sent16 < n_beats) && ($urandom_range(0, 3) != 0);
            bus16.A         = 16'($urandom);
            bus16.B         = 16'($urandom);
            bus16.Bin       = 1'($urandom_range(0, 1));
            bus16.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            obs8  = {bus8.V, bus8.Z, bus8.Bout, 24'd0, bus8.D};
            obs16 = {bus16.V, bus16.Z, bus16.Bout, 16'd0, bus16.D};

            if (hold8) begin
                total++; if (obs8 !== held8 || bus8.out_valid !== 1'b1) begin bad++; $display("FAIL rnd8_stall_hold got=%h want=%h", obs8, held8); end
            end
            if (hold16) begin
                total++; if (obs16 !== held16 || bus16.out_valid !== 1'b1) begin bad++; $display("FAIL rnd16_stall_hold got=%h want=%h", obs16, held16); end
            end
            hold8  = bus8.out_valid && !bus8.out_ready;
            held8  = obs8;
            hold16 = bus16.out_valid && !bus16.out_ready;
            held16 = obs16;

            if (bus8.out_valid && bus8.out_ready) begin
                total++;
                if (q8.size() == 0) begin
                    bad++; $display("FAIL rnd8_unexpected got=%h want=none", obs8);
                end else begin
                    exp_v = q8.pop_front();
                    if (obs8 !== exp_v) begin bad++; $display("FAIL rnd8_beat%0d got=%h want=%h", rcv8, obs8, exp_v); end
                end
                rcv8++;
            end
            if (bus16.out_valid && bus16.out_ready) begin
                total++;
                if (q16.size() == 0) begin
                    bad++; $display("FAIL rnd16_unexpected got=%h want=none", obs16);
                end else begin
                    exp_v = q16.pop_front();
                    if (obs16 !== exp_v) begin bad++; $display("FAIL rnd16_beat%0d got=%h want=%h", rcv16, obs16, exp_v); end
                end
                rcv16++;
            end
            if (bus8.in_valid && bus8.in_ready) begin
                q8.push_back(ref_model(8, longint'(bus8.A), longint'(bus8.B), longint'(bus8.Bin)));
                sent8++;
            end
            if (bus16.in_valid && bus16.in_ready) begin
                q16.push_back(ref_model(16, longint'(bus16.A), longint'(bus16.B), longint'(bus16.Bin)));
                sent16++;
            end
            @(negedge clk);
            cyc++;
        end
        idle_all();
        total++; if (rcv8 !== n_beats) begin bad++; $display("FAIL rnd8_count got=%0d want=%0d", rcv8, n_beats); end
        total++; if (rcv16 !== n_beats) begin bad++; $display("FAIL rnd16_count got=%0d want=%0d", rcv16, n_beats); end
        total++; if (q8.size() !== 0) begin bad++; $display("FAIL rnd8_leftover got=%0d want=0", q8.size()); end
        total++; if (q16.size() !== 0) begin bad++; $display("FAIL rnd16_leftover got=%0d want=0", q16.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
